// File: rtl/fs_pkg.sv
// fs_pkg: shared defaults and the controller state type for the
// frequency-synthesizer serial load sequencer.
//   FS_WORD_W     - default bits per serial word
//   FS_DIV        - default system clocks per serial-clock half-period
//   FS_LE_CYCLES  - default latch-enable width in serial-clock periods
//   FS_GAP_CYCLES - default idle clocks after latch-enable falls
package fs_pkg;

  localparam int FS_WORD_W     = 32;
  localparam int FS_DIV        = 4;
  localparam int FS_LE_CYCLES  = 2;
  localparam int FS_GAP_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    GAP      = 3'd4
  } fs_state_e;

endpackage

// File: rtl/fs_serial_shifter.sv
// fs_serial_shifter: LSB-first shift register with half-period divider and
// bit counter for the synthesizer's 3-wire load interface.
//   clk, srst  - system clock, synchronous active-high reset
//   load       - capture word into the shift register, bit counter to 0
//   start      - begin a word: serial clock low, divider restarted
//   word       - word to be shifted out
//   half_tick  - last system clock of the current serial-clock half-period
//   last_bit   - the bit currently presented is the final bit of the word
//   sclk       - serial clock
//   sdata      - serial data (0 once the word has been fully shifted)
module fs_serial_shifter
  import fs_pkg::*;
#(
  parameter int WORD_W = FS_WORD_W,
  parameter int DIV    = FS_DIV
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              half_tick,
  output logic              last_bit,
  output logic              sclk,
  output logic              sdata
);

  localparam int DIV_W = $clog2(DIV + 1);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  logic [WORD_W-1:0] shift_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic              sclk_reg;
  logic              active_reg;
  logic              fall_tick;

  assign half_tick = active_reg && (div_cnt_reg == DIV_LAST);
  // End of a high half-period: the device has sampled, move to the next bit.
  assign fall_tick = half_tick && sclk_reg;
  assign last_bit  = (bit_cnt_reg == BIT_LAST);
  assign sclk      = sclk_reg;
  assign sdata     = shift_reg[0];

  always_ff @(posedge clk) begin
    if (srst) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (load) begin
      shift_reg   <= word;
      bit_cnt_reg <= '0;
    end else if (fall_tick) begin
      if (last_bit) begin
        // Clearing the register keeps the data pin low through LATCH/GAP.
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
      end else begin
        shift_reg   <= shift_reg >> 1;
        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      div_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
      active_reg  <= 1'b0;
    end else if (start) begin
      div_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
      active_reg  <= 1'b1;
    end else if (active_reg) begin
      if (half_tick) begin
        div_cnt_reg <= '0;
        sclk_reg    <= ~sclk_reg;
        if (sclk_reg && last_bit) begin
          active_reg <= 1'b0;
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/fs_load_sequencer.sv
// fs_load_sequencer: shares the synthesizer's serial load pins between NREQ
// requesters. Round-robin arbitration, whole-word req/ack capture, LSB-first
// shift at a divided rate, latch-enable pulse, then an idle gap.
//   clkIN, rstIN - system clock, synchronous active-high reset
//   reqIN        - per-requester request level
//   dataIN       - requester i word on [i*WORD_W +: WORD_W]
//   ackOUT       - one-hot single-cycle capture pulse
//   grantOUT     - one-hot owner of the word in flight, 0 when idle
//   busyOUT      - high from capture until the end of the gap
//   doneOUT      - single-cycle pulse as latch-enable falls
//   clkOUT, dataOUT, leOUT - serial clock, data, latch enable
module fs_load_sequencer
  import fs_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int WORD_W     = FS_WORD_W,
  parameter int DIV        = FS_DIV,
  parameter int LE_CYCLES  = FS_LE_CYCLES,
  parameter int GAP_CYCLES = FS_GAP_CYCLES
) (
  input  logic                   clkIN,
  input  logic                   rstIN,
  input  logic [NREQ-1:0]        reqIN,
  input  logic [NREQ*WORD_W-1:0] dataIN,
  output logic [NREQ-1:0]        ackOUT,
  output logic [NREQ-1:0]        grantOUT,
  output logic                   busyOUT,
  output logic                   doneOUT,
  output logic                   clkOUT,
  output logic                   dataOUT,
  output logic                   leOUT
);

  localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LE_TOT  = LE_CYCLES * 2 * DIV;
  localparam int CNT_MAX = (LE_TOT > GAP_CYCLES) ? LE_TOT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LE_LAST  = CNT_W'(LE_TOT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NREQ - 1);

  fs_state_e         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [NREQ-1:0]   grant_reg, grant_next;
  logic [NREQ-1:0]   ack_reg, ack_next;
  logic              done_reg, done_next;

  logic [NREQ-1:0]   at_or_after;
  logic [NREQ-1:0]   masked_req;
  logic [NREQ-1:0]   pick_req;
  logic [PTR_W-1:0]  gnt_idx;
  logic [WORD_W-1:0] words [NREQ];
  logic              capture;
  logic              half_tick;
  logic              last_bit;
  logic              sclk;
  logic              sdata;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign words[gi]       = dataIN[gi*WORD_W +: WORD_W];
    assign at_or_after[gi] = (PTR_W'(gi) >= ptr_reg);
  end

  // Round-robin: lowest requester at or above the pointer, else wrap to the
  // lowest requester overall.
  always_comb begin
    masked_req = reqIN & at_or_after;
    pick_req   = (|masked_req) ? masked_req : reqIN;
    gnt_idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick_req[i]) begin
        gnt_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    ack_next   = '0;
    done_next  = 1'b0;
    capture    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (|reqIN) begin
          capture    = 1'b1;
          grant_next = NREQ'(1) << gnt_idx;
          ack_next   = NREQ'(1) << gnt_idx;
          ptr_next   = (gnt_idx == PTR_MAX) ? '0 : gnt_idx + PTR_W'(1);
          state_next = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (half_tick) begin
          state_next = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (half_tick) begin
          if (last_bit) begin
            state_next = LATCH;
            cnt_next   = '0;
          end else begin
            state_next = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (cnt_reg == LE_LAST) begin
          done_next = 1'b1;
          cnt_next  = '0;
          if (GAP_CYCLES == 0) begin
            state_next = IDLE;
            grant_next = '0;
          end else begin
            state_next = GAP;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          grant_next = '0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clkIN) begin
    if (rstIN) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
      grant_reg <= '0;
      ack_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      ack_reg   <= ack_next;
      done_reg  <= done_next;
    end
  end

  fs_serial_shifter #(
    .WORD_W (WORD_W),
    .DIV    (DIV)
  ) u_shifter (
    .clk       (clkIN),
    .srst      (rstIN),
    .load      (capture),
    .start     (capture),
    .word      (words[gnt_idx]),
    .half_tick (half_tick),
    .last_bit  (last_bit),
    .sclk      (sclk),
    .sdata     (sdata)
  );

  assign ackOUT   = ack_reg;
  assign grantOUT = grant_reg;
  assign doneOUT  = done_reg;
  assign busyOUT  = (state_reg != IDLE);
  assign leOUT    = (state_reg == LATCH);
  assign clkOUT   = sclk;
  assign dataOUT  = sdata;

endmodule

// File: tb/tb_fs_load_sequencer.sv
// tb_fs_load_sequencer: directed bench for fs_load_sequencer. One instance
// with DIV=4 carries most scenarios, a second with DIV=1 checks the fastest
// bit rate. Inputs are driven and outputs sampled on the falling clock edge.
module tb_fs_load_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req;
  logic [63:0] data;
  logic [1:0]  ack, grant;
  logic        busy, done, sclk, sdata, le;

  logic [1:0]  b_req;
  logic [63:0] b_data;
  logic [1:0]  b_ack, b_grant;
  logic        b_busy, b_done, b_sclk, b_sdata, b_le;

  fs_load_sequencer #(.NREQ(2), .WORD_W(32), .DIV(4), .LE_CYCLES(2), .GAP_CYCLES(2)) dut (
    .clkIN(clk), .rstIN(rst), .reqIN(req), .dataIN(data), .ackOUT(ack), .grantOUT(grant),
    .busyOUT(busy), .doneOUT(done), .clkOUT(sclk), .dataOUT(sdata), .leOUT(le)
  );

  fs_load_sequencer #(.NREQ(2), .WORD_W(32), .DIV(1), .LE_CYCLES(2), .GAP_CYCLES(2)) dut_div1 (
    .clkIN(clk), .rstIN(rst), .reqIN(b_req), .dataIN(b_data), .ackOUT(b_ack), .grantOUT(b_grant),
    .busyOUT(b_busy), .doneOUT(b_done), .clkOUT(b_sclk), .dataOUT(b_sdata), .leOUT(b_le)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and output monitors.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   a_rise_cyc[$];
  logic a_rise_dat[$];
  logic a_prev_sclk = 1'b0, a_prev_le = 1'b0;
  int   a_le_cnt = 0, a_done_cnt = 0, a_done_ok = 0, a_busy_cnt = 0;
  int   a_le_clk_err = 0, a_le_rise_cyc = 0, a_gnt_err = 0;

  always @(negedge clk) begin
    if (sclk && !a_prev_sclk) begin
      a_rise_cyc.push_back(cyc);
      a_rise_dat.push_back(sdata);
    end
    if (le) a_le_cnt <= a_le_cnt + 1;
    if (le && (sclk || sdata)) a_le_clk_err <= a_le_clk_err + 1;
    if (le && !a_prev_le) a_le_rise_cyc <= cyc;
    if (done) a_done_cnt <= a_done_cnt + 1;
    if (done && a_prev_le && !le) a_done_ok <= a_done_ok + 1;
    if (busy) a_busy_cnt <= a_busy_cnt + 1;
    if ($countones(grant) > 1 || $countones(ack) > 1) a_gnt_err <= a_gnt_err + 1;
    a_prev_sclk <= sclk;
    a_prev_le   <= le;
  end

  int   b_rise_cyc[$];
  logic b_rise_dat[$];
  logic b_prev_sclk = 1'b0, b_prev_le = 1'b0;
  int   b_le_rise_cyc = 0;

  always @(negedge clk) begin
    if (b_sclk && !b_prev_sclk) begin
      b_rise_cyc.push_back(cyc);
      b_rise_dat.push_back(b_sdata);
    end
    if (b_le && !b_prev_le) b_le_rise_cyc <= cyc;
    b_prev_sclk <= b_sclk;
    b_prev_le   <= b_le;
  end

  function automatic logic [31:0] a_word(input int base);
    logic [31:0] w;
    w = 'x;
    if (a_rise_dat.size() >= base + 32)
      for (int i = 0; i < 32; i++) w[i] = a_rise_dat[base + i];
    return w;
  endfunction

  function automatic int a_spacing_err(input int base, input int n, input int period);
    int e;
    e = 0;
    if (a_rise_cyc.size() < base + n) return n;
    for (int i = 1; i < n; i++)
      if (a_rise_cyc[base + i] - a_rise_cyc[base + i - 1] != period) e++;
    return e;
  endfunction

  function automatic logic [31:0] b_word(input int base);
    logic [31:0] w;
    w = 'x;
    if (b_rise_dat.size() >= base + 32)
      for (int i = 0; i < 32; i++) w[i] = b_rise_dat[base + i];
    return w;
  endfunction

  function automatic int b_spacing_err(input int base, input int n, input int period);
    int e;
    e = 0;
    if (b_rise_cyc.size() < base + n) return n;
    for (int i = 1; i < n; i++)
      if (b_rise_cyc[base + i] - b_rise_cyc[base + i - 1] != period) e++;
    return e;
  endfunction

  task automatic wait_ack(input int limit, output logic [1:0] who, output int lat);
    who = '0;
    lat = 0;
    while (lat < limit) begin
      @(negedge clk);
      lat++;
      if (|ack) begin
        who = ack;
        $display("[cyc %0d] ack=%b grant=%b after %0d cycles", cyc, ack, grant, lat);
        return;
      end
    end
  endtask

  task automatic wait_done(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " ack"},   ack,   2'b00);
    check_eq({tag, " grant"}, grant, 2'b00);
    check_eq({tag, " busy"},  busy,  1'b0);
    check_eq({tag, " done"},  done,  1'b0);
    check_eq({tag, " sclk"},  sclk,  1'b0);
    check_eq({tag, " sdata"}, sdata, 1'b0);
    check_eq({tag, " le"},    le,    1'b0);
  endtask

  initial begin
    logic [1:0] who;
    int lat, base, ack_cyc, prev_ack, n, early;
    int le0, done0, dok0, busy0;
    bit found;

    rst = 1'b1; req = '0; data = '0; b_req = '0; b_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single word 0x00000010 from requester 0.
    base = a_rise_cyc.size();
    le0 = a_le_cnt; done0 = a_done_cnt; dok0 = a_done_ok; busy0 = a_busy_cnt;
    data[31:0] = 32'h0000_0010; req = 2'b01;
    wait_ack(10, who, lat);
    req = '0; ack_cyc = cyc;
    check_eq("t1 ack who", who, 2'b01);
    check_eq("t1 ack latency", lat, 1);
    check_eq("t1 grant", grant, 2'b01);
    check_eq("t1 busy", busy, 1'b1);
    check_eq("t1 sclk low", sclk, 1'b0);
    check_eq("t1 bit0", sdata, 1'b0);
    @(negedge clk);
    check_eq("t1 ack width", ack, 2'b00);
    wait_done(400, found);
    check_eq("t1 done seen", found, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("t1 rise count", a_rise_cyc.size() - base, 32);
    check_eq("t1 first rise", (a_rise_cyc.size() > base) ? a_rise_cyc[base] - ack_cyc : -1, 4);
    check_eq("t1 bit period", a_spacing_err(base, 32, 8), 0);
    check_eq("t1 word", a_word(base), 32'h0000_0010);
    check_eq("t1 le width", a_le_cnt - le0, 16);
    check_eq("t1 done count", a_done_cnt - done0, 1);
    check_eq("t1 done at le fall", a_done_ok - dok0, 1);
    check_eq("t1 busy width", a_busy_cnt - busy0, 274);
    check_eq("t1 le vs last rise",
             (a_rise_cyc.size() > 0) ? a_le_rise_cyc - a_rise_cyc[a_rise_cyc.size() - 1] : -1, 4);
    check_eq("t1 grant idle", grant, 2'b00);

    // Both requesters held from reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = a_rise_cyc.size();
    data = {32'h0F0F_0F0F, 32'hA5A5_A5A5}; req = 2'b11;
    prev_ack = 0;
    for (int wi = 0; wi < 4; wi++) begin
      wait_ack(300, who, lat);
      check_eq($sformatf("rr%0d who", wi), who, (wi % 2 == 0) ? 2'b01 : 2'b10);
      if (wi == 0) check_eq("rr0 latency", lat, 1);
      else check_eq($sformatf("rr%0d ack spacing", wi), cyc - prev_ack, 275);
      prev_ack = cyc;
    end
    req = '0;
    wait_idle(400, found);
    check_eq("rr idle reached", found, 1'b1);
    repeat (2) @(negedge clk);
    check_eq("rr rise count", a_rise_cyc.size() - base, 128);
    check_eq("rr word0", a_word(base),      32'hA5A5_A5A5);
    check_eq("rr word1", a_word(base + 32), 32'h0F0F_0F0F);
    check_eq("rr word2", a_word(base + 64), 32'hA5A5_A5A5);
    check_eq("rr word3", a_word(base + 96), 32'h0F0F_0F0F);
    check_eq("rr one-hot", a_gnt_err, 0);

    // Requester 1 arrives mid-shift: held off until IDLE, acked one cycle later.
    data[31:0] = 32'h1234_5678; data[63:32] = 32'hCAFE_F00D; req = 2'b01;
    wait_ack(10, who, lat);
    req = '0;
    check_eq("hold first who", who, 2'b01);
    repeat (50) @(negedge clk);
    req[1] = 1'b1;
    early = 0; n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
      if (|ack) early++;
    end
    check_eq("hold no early ack", early, 0);
    check_eq("hold idle busy", busy, 1'b0);
    check_eq("hold idle grant", grant, 2'b00);
    base = a_rise_cyc.size();
    wait_ack(10, who, lat);
    req = '0;
    check_eq("hold ack who", who, 2'b10);
    check_eq("hold ack latency", lat, 1);

    // Requester 0 pulses one cycle while busy, then drops: never granted.
    repeat (20) @(negedge clk);
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    early = 0; n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
      if (|ack) early++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (|ack) early++;
    end
    check_eq("pulse no ack", early, 0);
    check_eq("pulse grant idle", grant, 2'b00);
    check_eq("pulse busy idle", busy, 1'b0);
    check_eq("hold word1", a_word(base), 32'hCAFE_F00D);

    // Reset at the 10th bit: outputs clear, no done, pointer back to 0.
    data[31:0] = 32'hDEAD_BEEF; req = 2'b01;
    wait_ack(10, who, lat);
    req = '0;
    check_eq("rst word who", who, 2'b01);
    base = a_rise_cyc.size();
    done0 = a_done_cnt;
    n = 0;
    while (a_rise_cyc.size() < base + 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid-word reset");
    rst = 1'b0;
    data = {32'h2468_ACE0, 32'h1357_9BDF}; req = 2'b11;
    base = a_rise_cyc.size();
    wait_ack(10, who, lat);
    req[0] = 1'b0;
    check_eq("post-rst who", who, 2'b01);
    check_eq("post-rst latency", lat, 1);
    wait_ack(300, who, lat);
    req = '0;
    check_eq("post-rst second who", who, 2'b10);
    check_eq("post-rst done count", a_done_cnt - done0, 1);
    wait_idle(400, found);
    repeat (2) @(negedge clk);
    check_eq("post-rst rise count", a_rise_cyc.size() - base, 64);
    check_eq("post-rst word0", a_word(base),      32'h1357_9BDF);
    check_eq("post-rst word1", a_word(base + 32), 32'h2468_ACE0);

    // DIV=1 instance, MSB-only word.
    base = b_rise_cyc.size();
    b_data[31:0] = 32'h8000_0000; b_req = 2'b01;
    n = 0;
    while (!(|b_ack) && n < 10) begin
      @(negedge clk);
      n++;
    end
    b_req = '0;
    ack_cyc = cyc;
    $display("[cyc %0d] div1 ack=%b after %0d cycles", cyc, b_ack, n);
    check_eq("d1 ack who", b_ack, 2'b01);
    check_eq("d1 ack latency", n, 1);
    n = 0;
    while (b_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("d1 idle", b_busy, 1'b0);
    check_eq("d1 rise count", b_rise_cyc.size() - base, 32);
    check_eq("d1 first rise", (b_rise_cyc.size() > base) ? b_rise_cyc[base] - ack_cyc : -1, 1);
    check_eq("d1 bit period", b_spacing_err(base, 32, 2), 0);
    check_eq("d1 word", b_word(base), 32'h8000_0000);
    check_eq("d1 le vs last rise",
             (b_rise_cyc.size() > 0) ? b_le_rise_cyc - b_rise_cyc[b_rise_cyc.size() - 1] : -1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
